// File: rtl/axi4lite_regbank_if.sv
// AXI4-Lite bundle between a bus master and the register bank.
// The master drives requests and the bank drives ready and response signals.
interface axi4lite_regbank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave holding NUM_REGS word registers with optional read-only slots.
// The write path and the read path run as two independent small FSMs.
module axi4lite_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi4lite_regbank_if.slave              axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(STRB_W);
  localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_ok;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [IDX_W-1:0]      ar_idx;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  // Protection bits and sub-word address bits carry no meaning for this bank.
  logic unused;
  assign unused = ^{axi.AWPROT, axi.ARPROT,
                    axi.AWADDR[IDX_LSB-1:0], axi.ARADDR[IDX_LSB-1:0]};

  // ---------------- write path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_state_nxt = w_state;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi.AWREADY = !ARESET && !aw_held;
        axi.WREADY  = !ARESET && !w_held;
        commit      = aw_held && w_held;
        if (commit) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (axi.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs = axi.AWVALID && axi.AWREADY;
  assign w_hs  = axi.WVALID && axi.WREADY;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = (aw_idx_q == IDX_W'(i)) && !RO_MASK[i];
  end
  assign wr_ok = |wr_sel;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      // NOTE: the register file is flops that software reads back, so every word is reset.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      axi.BVALID <= 1'b0;
      axi.BRESP  <= RESP_OKAY;
      wr_pulse   <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values, whatever the statement order.
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= axi.AWADDR[ADDR_WIDTH-1:IDX_LSB];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= axi.WDATA;
        w_strb_q <= axi.WSTRB;
      end
      if (commit) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        axi.BVALID <= 1'b1;
        axi.BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        wr_pulse   <= wr_sel;
        for (int i = 0; i < NUM_REGS; i++)
          for (int b = 0; b < STRB_W; b++)
            if (wr_sel[i] && w_strb_q[b]) regs[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end else if (axi.BVALID && axi.BREADY) begin
        axi.BVALID <= 1'b0;
      end
    end
  end

  // ---------------- read path ----------------
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    axi.ARREADY = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi.ARREADY = !ARESET;
        if (axi.ARVALID && !ARESET) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (axi.RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs  = axi.ARVALID && axi.ARREADY;
  assign ar_idx = axi.ARADDR[ADDR_WIDTH-1:IDX_LSB];

  // Read-only slots return the live hardware value captured at the address handshake.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      axi.RVALID <= 1'b0;
      axi.RDATA  <= '0;
      axi.RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      axi.RVALID <= 1'b1;
      axi.RDATA  <= rd_hit ? rd_val : '0;
      axi.RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (axi.RVALID && axi.RREADY) begin
      axi.RVALID <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end
endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed bench: bank A uses defaults, bank B marks register 3 read-only.
// Both banks see identical master traffic; responses are compared against hand-computed values.
module tb_axi4lite_regbank;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 4;

  logic           ACLK   = 1'b0;
  logic           ARESET = 1'b1;
  logic [NR*DW-1:0] reg_out_a, reg_out_b;
  logic [NR*DW-1:0] reg_in_a, reg_in_b;
  logic [NR-1:0]    wr_pulse_a, wr_pulse_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a [NR] = '{default: 0};
  int cnt_b [NR] = '{default: 0};

  logic [1:0]  resp_a, resp_b;
  logic [31:0] rdata_a, rdata_b;

  axi4lite_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  axi4lite_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  assign bus_b.AWADDR  = bus_a.AWADDR;
  assign bus_b.AWPROT  = bus_a.AWPROT;
  assign bus_b.AWVALID = bus_a.AWVALID;
  assign bus_b.WDATA   = bus_a.WDATA;
  assign bus_b.WSTRB   = bus_a.WSTRB;
  assign bus_b.WVALID  = bus_a.WVALID;
  assign bus_b.BREADY  = bus_a.BREADY;
  assign bus_b.ARADDR  = bus_a.ARADDR;
  assign bus_b.ARPROT  = bus_a.ARPROT;
  assign bus_b.ARVALID = bus_a.ARVALID;
  assign bus_b.RREADY  = bus_a.RREADY;

  axi4lite_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(4'b0000)) dut_a (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .axi      (bus_a.slave),
    .reg_out  (reg_out_a),
    .reg_in   (reg_in_a),
    .wr_pulse (wr_pulse_a)
  );

  axi4lite_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(4'b1000)) dut_b (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .axi      (bus_b.slave),
    .reg_out  (reg_out_b),
    .reg_in   (reg_in_b),
    .wr_pulse (wr_pulse_b)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    for (int i = 0; i < NR; i++) begin
      cnt_a[i] += int'(wr_pulse_a[i]);
      cnt_b[i] += int'(wr_pulse_b[i]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb,
                           output logic [1:0] ra, output logic [1:0] rb);
    logic aw_done, w_done, aw_now, w_now;
    int   cyc;
    bus_a.AWADDR  = addr;
    bus_a.WDATA   = data;
    bus_a.WSTRB   = strb;
    bus_a.AWVALID = 1'b1;
    bus_a.WVALID  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_now = bus_a.AWVALID && bus_a.AWREADY;
      w_now  = bus_a.WVALID && bus_a.WREADY;
      step();
      cyc++;
      if (aw_now) begin aw_done = 1'b1; bus_a.AWVALID = 1'b0; end
      if (w_now)  begin w_done  = 1'b1; bus_a.WVALID  = 1'b0; end
    end
    bus_a.AWVALID = 1'b0;
    bus_a.WVALID  = 1'b0;
    while (!bus_a.BVALID && cyc < 20) begin
      step();
      cyc++;
    end
    check("wr_bvalid", bus_a.BVALID, 1'b1);
    ra = bus_a.BRESP;
    rb = bus_b.BRESP;
    bus_a.BREADY = 1'b1;
    step();
    bus_a.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr,
                          output logic [31:0] da, output logic [1:0] ra,
                          output logic [31:0] db, output logic [1:0] rb);
    int cyc;
    bus_a.ARADDR  = addr;
    bus_a.ARVALID = 1'b1;
    cyc = 0;
    while (!bus_a.ARREADY && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    bus_a.ARVALID = 1'b0;
    while (!bus_a.RVALID && cyc < 20) begin
      step();
      cyc++;
    end
    check("rd_rvalid", bus_a.RVALID, 1'b1);
    da = bus_a.RDATA;
    ra = bus_a.RRESP;
    db = bus_b.RDATA;
    rb = bus_b.RRESP;
    bus_a.RREADY = 1'b1;
    step();
    bus_a.RREADY = 1'b0;
  endtask

  initial begin
    bus_a.AWADDR  = '0;
    bus_a.AWPROT  = 3'b000;
    bus_a.AWVALID = 1'b0;
    bus_a.WDATA   = '0;
    bus_a.WSTRB   = '0;
    bus_a.WVALID  = 1'b0;
    bus_a.BREADY  = 1'b0;
    bus_a.ARADDR  = '0;
    bus_a.ARPROT  = 3'b000;
    bus_a.ARVALID = 1'b0;
    bus_a.RREADY  = 1'b0;
    reg_in_a = '0;
    reg_in_b = {32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333};

    // Reset state
    ARESET = 1'b1;
    repeat (3) step();
    check("rst_awready", bus_a.AWREADY, 1'b0);
    check("rst_wready",  bus_a.WREADY,  1'b0);
    check("rst_arready", bus_a.ARREADY, 1'b0);
    check("rst_bvalid",  bus_a.BVALID,  1'b0);
    check("rst_rvalid",  bus_a.RVALID,  1'b0);
    check("rst_rdata",   bus_a.RDATA,   32'h0);
    check("rst_reg_out", reg_out_a,     128'h0);
    check("rst_pulse",   wr_pulse_a,    4'h0);
    ARESET = 1'b0;
    #1;
    check("post_rst_awready", bus_a.AWREADY, 1'b1);
    check("post_rst_arready", bus_a.ARREADY, 1'b1);

    // Basic write then read-back of all four registers
    for (int i = 0; i < NR; i++) begin
      axi_write(AW'(i * 4), 32'(i + 1), 4'hF, resp_a, resp_b);
      check("basic_bresp_a", resp_a, 2'b00);
      if (i == 3) check("ro_write_bresp_b", resp_b, 2'b10);
      else        check("rw_write_bresp_b", resp_b, 2'b00);
    end
    for (int i = 0; i < NR; i++) begin
      axi_read(AW'(i * 4), rdata_a, resp_a, rdata_b, resp_b);
      check("basic_rdata_a", rdata_a, 32'(i + 1));
      check("basic_rresp_a", resp_a, 2'b00);
      check("basic_rresp_b", resp_b, 2'b00);
      if (i == 3) check("ro_rdata_b", rdata_b, 32'hDEADBEEF);
      else        check("rw_rdata_b", rdata_b, 32'(i + 1));
    end
    for (int i = 0; i < NR; i++) check("pulse_cnt_a", cnt_a[i], 1);
    check("pulse_cnt_b0", cnt_b[0], 1);
    check("pulse_cnt_b3", cnt_b[3], 0);
    check("reg_out_a_basic", reg_out_a, {32'h4, 32'h3, 32'h2, 32'h1});
    check("reg_out_b_ro0",   reg_out_b, {32'h0, 32'h3, 32'h2, 32'h1});

    // Data three cycles ahead of address, two low byte lanes only
    bus_a.WDATA  = 32'hAABBCCDD;
    bus_a.WSTRB  = 4'b0011;
    bus_a.WVALID = 1'b1;
    check("early_wready", bus_a.WREADY, 1'b1);
    step();
    bus_a.WVALID = 1'b0;
    step();
    step();
    check("early_wready_low",  bus_a.WREADY,  1'b0);
    check("early_awready",     bus_a.AWREADY, 1'b1);
    check("early_bvalid_wait", bus_a.BVALID,  1'b0);
    bus_a.AWADDR  = 6'h04;
    bus_a.AWVALID = 1'b1;
    step();
    bus_a.AWVALID = 1'b0;
    check("early_bvalid_hs", bus_a.BVALID, 1'b0);
    step();
    check("early_bvalid", bus_a.BVALID,  1'b1);
    check("early_bresp",  bus_a.BRESP,   2'b00);
    check("early_pulse",  wr_pulse_a,    4'b0010);
    bus_a.BREADY = 1'b1;
    step();
    bus_a.BREADY = 1'b0;
    check("strobe_reg1", reg_out_a[63:32], 32'h0000CCDD);

    // Out-of-range index on both directions
    axi_write(6'h10, 32'h55555555, 4'hF, resp_a, resp_b);
    check("oor_bresp", resp_a, 2'b10);
    check("oor_regs",  reg_out_a, {32'h4, 32'h3, 32'h0000CCDD, 32'h1});
    axi_read(6'h10, rdata_a, resp_a, rdata_b, resp_b);
    check("oor_rdata", rdata_a, 32'h0);
    check("oor_rresp", resp_a, 2'b10);

    // Zero strobe with nonzero low address bits: OKAY, pulse, no change
    axi_write(6'h01, 32'hFFFFFFFF, 4'h0, resp_a, resp_b);
    check("zstrb_bresp", resp_a, 2'b00);
    check("zstrb_regs",  reg_out_a, {32'h4, 32'h3, 32'h0000CCDD, 32'h1});
    check("zstrb_cnt0",  cnt_a[0], 2);
    check("zstrb_cnt1",  cnt_a[1], 2);
    check("zstrb_cnt2",  cnt_a[2], 1);

    // Held response with a concurrent read of reg0
    bus_a.AWADDR  = 6'h08;
    bus_a.WDATA   = 32'h12345678;
    bus_a.WSTRB   = 4'hF;
    bus_a.AWVALID = 1'b1;
    bus_a.WVALID  = 1'b1;
    step();
    bus_a.AWVALID = 1'b0;
    bus_a.WVALID  = 1'b0;
    step();
    check("hold_bvalid_start", bus_a.BVALID, 1'b1);
    bus_a.ARADDR  = 6'h00;
    bus_a.ARVALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        bus_a.ARVALID = 1'b0;
        check("hold_rd_rvalid", bus_a.RVALID, 1'b1);
        check("hold_rd_rdata",  bus_a.RDATA,  32'h1);
        check("hold_rd_rresp",  bus_a.RRESP,  2'b00);
        bus_a.RREADY = 1'b1;
      end
      if (i == 1) begin
        bus_a.RREADY = 1'b0;
        check("hold_rd_done", bus_a.RVALID, 1'b0);
      end
      check("hold_bvalid",  bus_a.BVALID,  1'b1);
      check("hold_bresp",   bus_a.BRESP,   2'b00);
      check("hold_awready", bus_a.AWREADY, 1'b0);
      check("hold_wready",  bus_a.WREADY,  1'b0);
    end
    bus_a.BREADY = 1'b1;
    step();
    bus_a.BREADY = 1'b0;
    check("hold_release", bus_a.BVALID,  1'b0);
    check("hold_idle",    bus_a.AWREADY, 1'b1);
    check("hold_reg2",    reg_out_a[95:64], 32'h12345678);

    // Read handshake on the commit edge returns the pre-write value
    bus_a.AWADDR  = 6'h00;
    bus_a.WDATA   = 32'hCAFE0000;
    bus_a.WSTRB   = 4'hF;
    bus_a.AWVALID = 1'b1;
    bus_a.WVALID  = 1'b1;
    step();
    bus_a.AWVALID = 1'b0;
    bus_a.WVALID  = 1'b0;
    bus_a.ARADDR  = 6'h00;
    bus_a.ARVALID = 1'b1;
    check("race_arready", bus_a.ARREADY, 1'b1);
    step();
    bus_a.ARVALID = 1'b0;
    check("race_bvalid", bus_a.BVALID, 1'b1);
    check("race_rvalid", bus_a.RVALID, 1'b1);
    check("race_rdata",  bus_a.RDATA,  32'h1);
    check("race_reg0",   reg_out_a[31:0], 32'hCAFE0000);
    bus_a.RREADY = 1'b1;
    bus_a.BREADY = 1'b1;
    step();
    bus_a.RREADY = 1'b0;
    bus_a.BREADY = 1'b0;

    // Reset while data waits for its address
    bus_a.WDATA  = 32'h00000099;
    bus_a.WSTRB  = 4'hF;
    bus_a.WVALID = 1'b1;
    step();
    bus_a.WVALID = 1'b0;
    check("mid_w_latched", bus_a.WREADY, 1'b0);
    ARESET = 1'b1;
    #1;
    check("mid_rst_awready", bus_a.AWREADY, 1'b0);
    check("mid_rst_arready", bus_a.ARREADY, 1'b0);
    step();
    ARESET = 1'b0;
    #1;
    check("mid_rst_wready", bus_a.WREADY, 1'b1);
    check("mid_rst_regs",   reg_out_a, 128'h0);
    bus_a.AWADDR  = 6'h00;
    bus_a.AWVALID = 1'b1;
    step();
    bus_a.AWVALID = 1'b0;
    step();
    check("mid_no_commit", bus_a.BVALID, 1'b0);
    check("mid_no_regs",   reg_out_a, 128'h0);

    // Supply fresh data, then reset while the response is pending
    bus_a.WDATA  = 32'h00000077;
    bus_a.WVALID = 1'b1;
    step();
    bus_a.WVALID = 1'b0;
    step();
    check("resp_pending", bus_a.BVALID, 1'b1);
    check("resp_reg0",    reg_out_a[31:0], 32'h77);
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("resp_rst_bvalid", bus_a.BVALID, 1'b0);
    check("resp_rst_regs_a", reg_out_a, 128'h0);
    check("resp_rst_regs_b", reg_out_b, 128'h0);
    #1;

    // Bank usable again after reset
    axi_write(6'h0C, 32'h0000005A, 4'hF, resp_a, resp_b);
    check("after_rst_bresp", resp_a, 2'b00);
    axi_read(6'h0C, rdata_a, resp_a, rdata_b, resp_b);
    check("after_rst_rdata", rdata_a, 32'h5A);
    check("after_rst_ro_b",  rdata_b, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4lite_regbank.md
AXI4LITE_REGBANK -- requirements
Module: axi4lite_regbank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning AXI byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 4, meaning register count (1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 SHALL have parameter RO_MASK, default 0, meaning NUM_REGS-bit mask where bit i=1 makes register i read-only.
REQ-005 ACLK  in  1  sole clock, all logic on rising edge.
REQ-006 ARESET  in  1  reset; synchronous, active-high.
REQ-007 AWADDR  in  ADDR_WIDTH, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1  write-address channel.
REQ-008 WDATA  in  DATA_WIDTH, WSTRB in DATA_WIDTH/8, WVALID in 1, WREADY out 1  write-data channel.
REQ-009 BRESP  out  2, BVALID out 1, BREADY in 1  write-response channel.
REQ-010 ARADDR  in  ADDR_WIDTH, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1  read-address channel.
REQ-011 RDATA  out  DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1  read-data channel.
REQ-012 reg_out  out  NUM_REGS*DATA_WIDTH  stored RW register values; register i at slice i.
REQ-013 reg_in  in  NUM_REGS*DATA_WIDTH  hardware values returned for RO registers.
REQ-014 wr_pulse  out  NUM_REGS  one-cycle strobe, bit i after committed write to register i.

Function
REQ-015 Register index SHALL be ADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low address bits ignored.
REQ-016 Write FSM SHALL have states W_IDLE, W_RESP; AW and W handshakes accepted independently, in either order or same cycle.
REQ-017 In W_IDLE AWREADY SHALL be 1 while no address latched, WREADY 1 while no data latched; each drops to 0 the cycle after its handshake.
REQ-018 When both address and data latched, write SHALL commit in that cycle; BVALID=1 and FSM to W_RESP on next edge (latency 1 cycle after later handshake).
REQ-019 Commit SHALL update only byte lanes with WSTRB bit set; WSTRB=0 gives BRESP OKAY with no change, wr_pulse still asserted.
REQ-020 Index >= NUM_REGS or RO_MASK[index]=1 SHALL give BRESP=2'b10 (SLVERR), no register change, no wr_pulse; otherwise BRESP=2'b00.
REQ-021 In W_RESP, AWREADY=WREADY=0; BVALID/BRESP held stable until BREADY=1, then W_IDLE on next edge (max one write per 2 cycles).
REQ-022 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; on AR handshake RDATA/RRESP/RVALID=1 registered next cycle.
REQ-023 RDATA SHALL be stored value (RW), reg_in slice sampled at AR handshake (RO), or 0 with RRESP=2'b10 (index >= NUM_REGS).
REQ-024 RVALID/RDATA SHALL be held stable until RREADY=1, then R_IDLE on next edge.
REQ-025 Read and write FSMs SHALL be independent; read handshake in same cycle as write commit to same register SHALL return pre-write value.
REQ-026 reg_out slices for RO registers SHALL be 0.

Reset
REQ-027 ARESET=1 at a rising edge SHALL clear all registers, latches, BVALID, RVALID, wr_pulse, RDATA, BRESP, RRESP to 0 and force W_IDLE/R_IDLE; AWREADY/WREADY/ARREADY SHALL be 0 while ARESET=1.
REQ-028 Reset mid-transaction SHALL discard any latched address/data without committing; first handshake accepted in the cycle after ARESET deasserts.

Verification
REQ-029 Defaults: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read same -> RDATA 0x1..0x4, all BRESP/RRESP 2'b00, wr_pulse bits 0..3 each high exactly once.
REQ-030 Reg1=0x00000002; WVALID (0xAABBCCDD, WSTRB 4'b0011) 3 cycles before AWVALID 0x4 -> BVALID 1 cycle after AW handshake, reg1=0x0000CCDD.
REQ-031 Write/read 0x10 with NUM_REGS=4 -> BRESP 2'b10, regs unchanged, no wr_pulse; RDATA 0, RRESP 2'b10.
REQ-032 RO_MASK=4'b1000, reg_in[3]=0xDEADBEEF: read 0xC -> 0xDEADBEEF OKAY; write 0xC -> SLVERR, wr_pulse[3]=0, reg_out[3]=0.
REQ-033 BREADY low 10 cycles after write -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; concurrent read to reg0 completes normally.
REQ-034 ARESET pulsed while data latched awaiting AW, and again while BVALID=1 -> no commit, BVALID 0 next cycle, all regs 0.
